// File: rtl/unframer_if.sv
// rtl/unframer_if.sv - raw byte input and framed byte output stream bundle for the unframer
interface unframer_if;
  logic       target_tvalid;
  logic       target_tready;
  logic [7:0] target_tdata;
  logic       initiator_tvalid;
  logic       initiator_tready;
  logic [7:0] initiator_tdata;
  logic       initiator_tlast;

  modport slave (
    input  target_tvalid, target_tdata, initiator_tready,
    output target_tready, initiator_tvalid, initiator_tdata, initiator_tlast
  );

  modport master (
    output target_tvalid, target_tdata, initiator_tready,
    input  target_tready, initiator_tvalid, initiator_tdata, initiator_tlast
  );
endinterface

// File: rtl/unframer.sv
// rtl/unframer.sv - strips START/STOP delimiters from a raw byte stream, keeps escapes, marks tlast
module unframer (
  input  logic      aclk,
  input  logic      areset,
  unframer_if.slave bus,
  output logic      frame_error
);
  localparam logic [7:0] START_BYTE  = 8'h7D;
  localparam logic [7:0] STOP_BYTE   = 8'h7E;
  localparam logic [7:0] ESCAPE_BYTE = 8'h7F;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t     state_q, state_d;
  logic       h_valid_q, h_valid_d;
  logic [7:0] h_data_q, h_data_d;
  logic       esc_q, esc_d;
  logic       o_valid_q, o_valid_d;
  logic [7:0] o_data_q, o_data_d;
  logic       o_last_q, o_last_d;
  logic       frame_error_q, frame_error_d;

  logic accept;
  logic is_start;
  logic is_stop;

  assign bus.target_tready = !areset && (!o_valid_q || bus.initiator_tready);
  assign accept   = bus.target_tvalid && bus.target_tready;
  assign is_start = !esc_q && (bus.target_tdata == START_BYTE);
  assign is_stop  = !esc_q && (bus.target_tdata == STOP_BYTE);

  always_comb begin
    state_d       = state_q;
    h_valid_d     = h_valid_q;
    h_data_d      = h_data_q;
    esc_d         = esc_q;
    o_valid_d     = o_valid_q;
    o_data_d      = o_data_q;
    o_last_d      = o_last_q;
    frame_error_d = 1'b0;

    if (o_valid_q && bus.initiator_tready) begin
      o_valid_d = 1'b0;
    end

    // The look-behind byte is only released once the next byte decides its tlast.
    if (accept) begin
      case (state_q)
        IDLE: begin
          esc_d = 1'b0;
          if (bus.target_tdata == START_BYTE) begin
            state_d   = IN_FRAME;
            h_valid_d = 1'b0;
          end
        end
        IN_FRAME: begin
          if (is_stop || is_start) begin
            if (h_valid_q) begin
              o_valid_d     = 1'b1;
              o_data_d      = h_data_q;
              o_last_d      = 1'b1;
              frame_error_d = is_start;
            end
            h_valid_d = 1'b0;
            esc_d     = 1'b0;
            state_d   = is_stop ? IDLE : IN_FRAME;
          end else begin
            if (h_valid_q) begin
              o_valid_d = 1'b1;
              o_data_d  = h_data_q;
              o_last_d  = 1'b0;
            end
            h_data_d  = bus.target_tdata;
            h_valid_d = 1'b1;
            esc_d     = (bus.target_tdata == ESCAPE_BYTE) && !esc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      h_valid_q     <= 1'b0;
      h_data_q      <= 8'h00;
      esc_q         <= 1'b0;
      o_valid_q     <= 1'b0;
      o_data_q      <= 8'h00;
      o_last_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_valid_q     <= h_valid_d;
      h_data_q      <= h_data_d;
      esc_q         <= esc_d;
      o_valid_q     <= o_valid_d;
      o_data_q      <= o_data_d;
      o_last_q      <= o_last_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign bus.initiator_tvalid = o_valid_q;
  assign bus.initiator_tdata  = o_data_q;
  assign bus.initiator_tlast  = o_last_q;
  assign frame_error          = frame_error_q;
endmodule

// File: doc/unframer.md
# unframer

Receive-side frame extractor for the byte-oriented AXI4-Stream framing path. It sits directly upstream of the de-escaper. It takes a raw, untimed byte stream from the link, hunts for unescaped START bytes, and strips START/STOP delimiters. It forwards every in-frame byte, with escape bytes preserved, so the de-escaper can remove them. The last data byte of each frame is marked with tlast.

## Interface
- START_BYTE, 8'h7D, frame-start delimiter.
- STOP_BYTE, 8'h7E, frame-end delimiter.
- ESCAPE_BYTE, 8'h7F, escape marker; the byte following it is always data.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- target_tvalid  in  1  raw byte valid.
- target_tready  out  1  raw byte accepted.
- target_tdata  in  8  raw byte.
- initiator_tvalid  out  1  framed byte valid; registered.
- initiator_tready  in  1  downstream ready.
- initiator_tdata  out  8  framed byte, still escaped; registered.
- initiator_tlast  out  1  last byte of frame; registered.
- frame_error  out  1  one-cycle pulse when a frame is truncated by an unescaped START.

## Operation
- Storage:
  - output register O: o_valid, data, last.
  - look-behind register H: h_valid, data.
  - escape flag esc.
  - state: IDLE or IN_FRAME.
- Accept condition: accept = target_tvalid && target_tready.
- target_tready = !areset && (!o_valid || initiator_tready).
- A byte is "unescaped" when esc == 0.
- IDLE:
  - Every accepted byte is discarded.
  - Unescaped START moves to IN_FRAME with h_valid = 0 and esc = 0.
  - esc is ignored (held 0) in IDLE.
- IN_FRAME, accepted byte B:
  - Unescaped STOP:
    - If h_valid, O <= {H, last=1} and h_valid <= 0.
    - If H is empty (empty frame), nothing is emitted and there is no error.
    - Next state IDLE.
  - Unescaped START:
    - If h_valid, O <= {H, last=1}, h_valid <= 0, and frame_error pulses.
    - Stay in IN_FRAME; this is the start of a new frame.
    - If H is empty, it silently resyncs with no error.
  - Otherwise B is data, including ESCAPE bytes and escaped START/STOP:
    - If h_valid, O <= {H, last=0}.
    - Then H <= B and h_valid <= 1.
    - esc <= (B == ESCAPE_BYTE) && !esc.
    - A double ESCAPE yields esc = 0.
- O is cleared when initiator_tvalid && initiator_tready and no new load occurs in the same cycle.
- A load into O and a downstream handshake in the same cycle is legal: O is replaced.
- O contents are stable while initiator_tvalid && !initiator_tready.
- No byte is duplicated or dropped except the deliberately discarded bytes: IDLE bytes, delimiters, and empty frames.

## Timing
- Reset values (asynchronous on areset):
  - state = IDLE, h_valid = 0, esc = 0.
  - initiator_tvalid = 0, initiator_tdata = 8'h00, initiator_tlast = 0.
  - frame_error = 0.
  - target_tready = 0 while areset is high.
- Reset mid-frame: partial frame state is lost. After release the block hunts for START; no tlast is generated for the lost frame.
- Latency:
  - A data byte accepted at cycle t is held in H.
  - It reaches O one cycle after the next in-frame byte (data, STOP, or START) is accepted.
  - That next byte's acceptance is the earliest point at which its tlast value is known.
- frame_error is high for exactly the cycle O is loaded with the truncated frame's final byte.
- Throughput: one byte per cycle when initiator_tready is held high.
- Back-pressure: target_tready drops in the same cycle that o_valid && !initiator_tready, combinationally from O state.

## Test plan
- Basic frame: 7D 11 22 7E, tready=1 → 11 (last=0), then 22 (last=1) one cycle after 7E is accepted; frame_error stays 0.
- Escapes preserved: 7D 7F 7E 7F 7F 33 7E → 7F, 7E, 7F, 7F, 33 (last=1 only on 33); the escaped 7E does not end the frame.
- Idle discard and empty frame: AA 7E 7D 7E 7D 44 7E → only 44 (last=1); no output for the empty frame; no error.
- Truncation: 7D 55 66 7D 77 7E → 55 (last=0); 66 (last=1) with a one-cycle frame_error pulse; 77 (last=1).
- Back-pressure: 7D 01..08 7E with initiator_tready low for 5 cycles mid-frame → target_tready low while O is full; output 01..08 is in order, no loss or duplication, O is stable while stalled, and last=1 only on 08.
- Reset mid-frame: assert areset after 7D 10 20 → all outputs reset immediately. Then send 30 7E 7D 40 7E → only 40 (last=1).
